// File: rtl/sum_game_ctrl.sv
// Two-player "sum to 0xF" front end: captures one nibble per player, presents the
// registered sum to the check block, shows the verdict on LEDs and tracks wins/timeouts.
module sum_game_ctrl #(
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] switches,
  input  logic       enter,
  input  logic [1:0] status,
  output logic [3:0] sum,
  output logic       sum_valid,
  output logic [1:0] player,
  output logic       led_green,
  output logic       led_red,
  output logic [3:0] wins,
  output logic       timeout
);

  localparam int MAX_CYCLES = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [1:0] {P1, P2, EVAL, SHOW} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    nib_a_reg, nib_a_next;
  logic [3:0]    sum_reg, sum_next;
  logic          sum_valid_reg, sum_valid_next;
  logic          led_green_reg, led_green_next;
  logic          led_red_reg, led_red_next;
  logic [3:0]    wins_reg, wins_next;
  logic          timeout_reg, timeout_next;
  logic          enter_q_reg;
  logic [TW-1:0] timer_reg, timer_next;
  logic          rise;

  // enter_q clears in reset, so a button held through reset release reads as one press
  assign rise = enter & ~enter_q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= P1;
      nib_a_reg     <= '0;
      sum_reg       <= '0;
      sum_valid_reg <= 1'b0;
      led_green_reg <= 1'b0;
      led_red_reg   <= 1'b0;
      wins_reg      <= '0;
      timeout_reg   <= 1'b0;
      enter_q_reg   <= 1'b0;
      timer_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      nib_a_reg     <= nib_a_next;
      sum_reg       <= sum_next;
      sum_valid_reg <= sum_valid_next;
      led_green_reg <= led_green_next;
      led_red_reg   <= led_red_next;
      wins_reg      <= wins_next;
      timeout_reg   <= timeout_next;
      enter_q_reg   <= enter;
      timer_reg     <= timer_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    nib_a_next     = nib_a_reg;
    sum_next       = sum_reg;
    sum_valid_next = sum_valid_reg;
    led_green_next = led_green_reg;
    led_red_next   = led_red_reg;
    wins_next      = wins_reg;
    timeout_next   = 1'b0;
    timer_next     = timer_reg;
    case (state_reg)
      P1: begin
        if (rise) begin
          nib_a_next = switches;
          timer_next = '0;
          state_next = P2;
        end
      end
      P2: begin
        timer_next = timer_reg + TW'(1);
        // a press on the expiry cycle takes priority over the abort
        if (rise) begin
          sum_next       = nib_a_reg + switches;
          sum_valid_next = 1'b1;
          state_next     = EVAL;
        end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_next = 1'b1;
          nib_a_next   = '0;
          state_next   = P1;
        end
      end
      EVAL: begin
        if (status == 2'b01) begin
          led_green_next = 1'b1;
          led_red_next   = 1'b0;
          if (wins_reg != 4'hf) wins_next = wins_reg + 4'd1;
        end else begin
          led_green_next = 1'b0;
          led_red_next   = 1'b1;
        end
        timer_next = '0;
        state_next = SHOW;
      end
      SHOW: begin
        if (timer_reg == TW'(SHOW_CYCLES - 1)) begin
          led_green_next = 1'b0;
          led_red_next   = 1'b0;
          sum_valid_next = 1'b0;
          timer_next     = '0;
          state_next     = P1;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: state_next = P1;
    endcase
  end

  always_comb begin
    case (state_reg)
      P1:      player = 2'b01;
      P2:      player = 2'b10;
      default: player = 2'b00;
    endcase
  end

  assign sum       = sum_reg;
  assign sum_valid = sum_valid_reg;
  assign led_green = led_green_reg;
  assign led_red   = led_red_reg;
  assign wins      = wins_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_sum_game_ctrl.sv
// Directed bench for sum_game_ctrl with short show/timeout windows; the check block
// is modelled combinationally, with an override to inject unusual status codes.
module tb_sum_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] switches;
  logic       enter;
  logic [1:0] status;
  logic [3:0] sum;
  logic       sum_valid;
  logic [1:0] player;
  logic       led_green;
  logic       led_red;
  logic [3:0] wins;
  logic       timeout;

  logic       force_en;
  logic [1:0] force_val;
  int         checks;
  int         errors;

  sum_game_ctrl #(.SHOW_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .switches(switches), .enter(enter), .status(status),
    .sum(sum), .sum_valid(sum_valid), .player(player), .led_green(led_green),
    .led_red(led_red), .wins(wins), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign status = force_en ? force_val : ((sum == 4'hf) ? 2'b01 : 2'b10);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // P1 entry: rising edge, then release; leaves the DUT in P2
  task automatic press_p1(input logic [3:0] sw);
    switches = sw; enter = 1'b1; tick();
    enter = 1'b0; tick();
  endtask

  task automatic do_round(input logic [3:0] a, input logic [3:0] b);
    press_p1(a);
    switches = b; enter = 1'b1; tick();
    enter = 1'b0; tick();
    $display("round: a=%h b=%h sum=%h green=%b red=%b wins=%0d", a, b, sum, led_green, led_red, wins);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enter = 1'b0; switches = 4'h0; force_en = 1'b0; force_val = 2'b00;
    tick(); tick();
    checks++; if (sum !== 4'h0) begin errors++; $display("FAIL reset_sum: got %h exp 0", sum); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid: got %b exp 0", sum_valid); end
    checks++; if (player !== 2'b01) begin errors++; $display("FAIL reset_player: got %b exp 01", player); end
    checks++; if ({led_green, led_red} !== 2'b00) begin errors++; $display("FAIL reset_leds: got %b exp 00", {led_green, led_red}); end
    checks++; if (wins !== 4'h0) begin errors++; $display("FAIL reset_wins: got %0d exp 0", wins); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b exp 0", timeout); end
    $display("reset: player=%b wins=%0d", player, wins);
    rst_n = 1'b1;
  endtask

  task automatic test_match();
    switches = 4'h7; enter = 1'b1; tick();
    checks++; if (player !== 2'b10) begin errors++; $display("FAIL match_p2_prompt: got %b exp 10", player); end
    enter = 1'b0; tick();
    switches = 4'h8; enter = 1'b1; tick();
    checks++; if (sum !== 4'hf) begin errors++; $display("FAIL match_sum: got %h exp f", sum); end
    checks++; if (sum_valid !== 1'b1) begin errors++; $display("FAIL match_sum_valid: got %b exp 1", sum_valid); end
    checks++; if ({led_green, led_red} !== 2'b00) begin errors++; $display("FAIL match_led_early: got %b exp 00", {led_green, led_red}); end
    checks++; if (player !== 2'b00) begin errors++; $display("FAIL match_eval_player: got %b exp 00", player); end
    enter = 1'b0; tick();
    checks++; if (wins !== 4'd1) begin errors++; $display("FAIL match_wins: got %0d exp 1", wins); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({led_green, led_red} !== 2'b10) begin errors++; $display("FAIL match_show%0d: leds got %b exp 10", i, {led_green, led_red}); end
      tick();
    end
    checks++; if ({led_green, led_red} !== 2'b00) begin errors++; $display("FAIL match_leds_off: got %b exp 00", {led_green, led_red}); end
    checks++; if (sum_valid !== 1'b0) begin errors++; $display("FAIL match_valid_off: got %b exp 0", sum_valid); end
    checks++; if (player !== 2'b01) begin errors++; $display("FAIL match_back_p1: got %b exp 01", player); end
    checks++; if (sum !== 4'hf) begin errors++; $display("FAIL match_sum_hold: got %h exp f", sum); end
    $display("round: a=7 b=8 sum=%h wins=%0d", sum, wins);
  endtask

  task automatic test_mismatch();
    press_p1(4'h9);
    switches = 4'ha; enter = 1'b1; tick();
    checks++; if (sum !== 4'h3) begin errors++; $display("FAIL wrap_sum: got %h exp 3", sum); end
    enter = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({led_green, led_red} !== 2'b01) begin errors++; $display("FAIL wrap_show%0d: leds got %b exp 01", i, {led_green, led_red}); end
      tick();
    end
    checks++; if ({led_green, led_red} !== 2'b00) begin errors++; $display("FAIL wrap_leds_off: got %b exp 00", {led_green, led_red}); end
    checks++; if (wins !== 4'd1) begin errors++; $display("FAIL wrap_wins: got %0d exp 1", wins); end
    $display("round: a=9 b=a sum=%h wins=%0d", sum, wins);
  endtask

  task automatic test_timeout();
    int pulses;
    press_p1(4'h5);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (timeout === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL to_early: got %0d pulses exp 0", pulses); end
    checks++; if (player !== 2'b10) begin errors++; $display("FAIL to_still_p2: got %b exp 10", player); end
    tick();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b exp 1", timeout); end
    checks++; if (player !== 2'b01) begin errors++; $display("FAIL to_player: got %b exp 01", player); end
    checks++; if ({led_green, led_red} !== 2'b00) begin errors++; $display("FAIL to_leds: got %b exp 00", {led_green, led_red}); end
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %b exp 0", timeout); end
    $display("timeout: player=%b", player);
    // press lands on the expiry cycle: the round completes, no abort
    press_p1(4'h1);
    repeat (6) tick();
    switches = 4'he; enter = 1'b1; tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL expiry_race_pulse: got %b exp 0", timeout); end
    checks++; if ({sum_valid, sum} !== 5'h1f) begin errors++; $display("FAIL expiry_race_sum: got %b/%h exp 1/f", sum_valid, sum); end
    enter = 1'b0; tick();
    checks++; if (wins !== 4'd2) begin errors++; $display("FAIL expiry_race_wins: got %0d exp 2", wins); end
    repeat (4) tick();
    $display("round: a=1 b=e (expiry cycle) sum=%h wins=%0d", sum, wins);
  endtask

  task automatic test_hold_and_show_presses();
    int p2_cycles;
    int pulses;
    switches = 4'h3; enter = 1'b1; tick();
    p2_cycles = (player == 2'b10) ? 1 : 0;
    pulses = 0;
    switches = 4'hc;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (player == 2'b10) p2_cycles++;
      if (timeout === 1'b1) pulses++;
    end
    checks++; if (p2_cycles !== 8) begin errors++; $display("FAIL hold_p2_cycles: got %0d exp 8", p2_cycles); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_timeouts: got %0d exp 1", pulses); end
    checks++; if (player !== 2'b01) begin errors++; $display("FAIL hold_end_player: got %b exp 01", player); end
    enter = 1'b0; tick();
    $display("hold: p2_cycles=%0d timeouts=%0d", p2_cycles, pulses);
    press_p1(4'h7);
    switches = 4'h8; enter = 1'b1; tick();
    enter = 1'b0; tick();
    switches = 4'h1; enter = 1'b1; tick();
    checks++; if ({player, led_green} !== 3'b001) begin errors++; $display("FAIL show_press_ignored: player/green got %b exp 001", {player, led_green}); end
    enter = 1'b0; tick();
    enter = 1'b1; tick();
    enter = 1'b0; tick();
    checks++; if (player !== 2'b01) begin errors++; $display("FAIL show_exit_player: got %b exp 01", player); end
    checks++; if (sum !== 4'hf) begin errors++; $display("FAIL show_sum_kept: got %h exp f", sum); end
    tick();
    checks++; if (player !== 2'b01) begin errors++; $display("FAIL show_no_late_capture: got %b exp 01", player); end
    $display("round: a=7 b=8 with show presses wins=%0d", wins);
  endtask

  task automatic test_invalid_and_saturate();
    force_en = 1'b1; force_val = 2'b11;
    press_p1(4'h7);
    switches = 4'h8; enter = 1'b1; tick();
    enter = 1'b0; tick();
    checks++; if ({led_green, led_red} !== 2'b01) begin errors++; $display("FAIL status11_leds: got %b exp 01", {led_green, led_red}); end
    checks++; if (wins !== 4'd3) begin errors++; $display("FAIL status11_wins: got %0d exp 3", wins); end
    repeat (4) tick();
    force_val = 2'b00;
    do_round(4'h2, 4'hd);
    force_en = 1'b0;
    checks++; if (wins !== 4'd3) begin errors++; $display("FAIL status00_wins: got %0d exp 3", wins); end
    for (int i = 0; i < 11; i++) begin
      logic [3:0] a;
      a = 4'(i);
      do_round(a, 4'hf - a);
    end
    checks++; if (wins !== 4'd14) begin errors++; $display("FAIL wins_14: got %0d exp 14", wins); end
    for (int i = 11; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      do_round(a, 4'hf - a);
    end
    checks++; if (wins !== 4'd15) begin errors++; $display("FAIL wins_saturate: got %0d exp 15", wins); end
  endtask

  task automatic test_reset_in_show();
    press_p1(4'h2);
    switches = 4'hd; enter = 1'b1; tick();
    enter = 1'b0; tick();
    tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    checks++; if ({sum, sum_valid} !== 5'h00) begin errors++; $display("FAIL rst_show_sum: got %h/%b exp 0/0", sum, sum_valid); end
    checks++; if ({led_green, led_red, timeout} !== 3'b000) begin errors++; $display("FAIL rst_show_leds: got %b exp 000", {led_green, led_red, timeout}); end
    checks++; if (player !== 2'b01) begin errors++; $display("FAIL rst_show_player: got %b exp 01", player); end
    checks++; if (wins !== 4'h0) begin errors++; $display("FAIL rst_show_wins: got %0d exp 0", wins); end
    $display("reset in show: wins=%0d player=%b", wins, player);
    rst_n = 1'b0; switches = 4'h4; enter = 1'b1; tick();
    checks++; if (player !== 2'b01) begin errors++; $display("FAIL rst_held_player: got %b exp 01", player); end
    rst_n = 1'b1; tick();
    checks++; if (player !== 2'b10) begin errors++; $display("FAIL rst_release_rise: got %b exp 10", player); end
    enter = 1'b0; tick();
    $display("enter held across reset release: player=%b", player);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_match();
    test_mismatch();
    test_timeout();
    test_hold_and_show_presses();
    test_invalid_and_saturate();
    test_reset_in_show();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
